// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline package: datapath widths, control-bundle layout and the
// ID/EX register update selector.
package id_ex_stage_pkg;

  localparam int CTRL_W = 10;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // Bit positions inside the control bundle
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 4;
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int ALU_OP_W        = 4;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_dst;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_BUBBLE,
    UPD_HOLD,
    UPD_FLUSH
  } upd_t;

  // Flush beats Hold beats Stall; otherwise the stage loads.
  function automatic upd_t select_update(input logic flush, input logic hold,
                                         input logic stall);
    if (flush)      return UPD_FLUSH;
    else if (hold)  return UPD_HOLD;
    else if (stall) return UPD_BUBBLE;
    else            return UPD_LOAD;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, squash/freeze controls,
// load-use stall request and registered EX-stage state.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic              ID_valid;
  logic [REG_W-1:0]  ID_rs;
  logic [REG_W-1:0]  ID_rt;
  logic [REG_W-1:0]  ID_rd;
  logic [DATA_W-1:0] ID_rdata1;
  logic [DATA_W-1:0] ID_rdata2;
  logic [DATA_W-1:0] ID_imm;
  ctrl_t             ID_ctrl;
  logic              Flush;
  logic              Hold;
  logic              Stall;
  logic              EX_valid;
  logic [REG_W-1:0]  EX_rs;
  logic [REG_W-1:0]  EX_rt;
  logic [REG_W-1:0]  EX_rd;
  logic [DATA_W-1:0] EX_rdata1;
  logic [DATA_W-1:0] EX_rdata2;
  logic [DATA_W-1:0] EX_imm;
  ctrl_t             EX_ctrl;

  modport master (
    output ID_valid, ID_rs, ID_rt, ID_rd, ID_rdata1, ID_rdata2, ID_imm, ID_ctrl,
    output Flush, Hold,
    input  Stall,
    input  EX_valid, EX_rs, EX_rt, EX_rd, EX_rdata1, EX_rdata2, EX_imm, EX_ctrl
  );

  modport slave (
    input  ID_valid, ID_rs, ID_rt, ID_rd, ID_rdata1, ID_rdata2, ID_imm, ID_ctrl,
    input  Flush, Hold,
    output Stall,
    output EX_valid, EX_rs, EX_rt, EX_rd, EX_rdata1, EX_rdata2, EX_imm, EX_ctrl
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: a valid load in EX whose destination
// feeds the instruction in ID requests a one-cycle stall.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  input  logic             hold,
  output logic             stall
);

  logic load_use;

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_valid && ex_mem_read && id_valid && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  assign stall = load_use && !flush && !hold;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional HAZ_PERF_CNT_EN adds a saturating bubble counter (BubbleCnt).
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  id_ex_stage_if.slave       bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [DATA_W-1:0]  BubbleCnt
`endif
);

  logic stall;
  upd_t upd;

  hazard_detect u_hazard_detect (
    .ex_valid    (bus.EX_valid),
    .ex_mem_read (bus.EX_ctrl.mem_read),
    .ex_rt       (bus.EX_rt),
    .id_valid    (bus.ID_valid),
    .id_rs       (bus.ID_rs),
    .id_rt       (bus.ID_rt),
    .flush       (bus.Flush),
    .hold        (bus.Hold),
    .stall       (stall)
  );

  assign bus.Stall = stall;
  assign upd       = select_update(bus.Flush, bus.Hold, stall);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the stall path reads EX_* in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.EX_valid  <= 1'b0;
      bus.EX_rs     <= '0;
      bus.EX_rt     <= '0;
      bus.EX_rd     <= '0;
      bus.EX_rdata1 <= '0;
      bus.EX_rdata2 <= '0;
      bus.EX_imm    <= '0;
      bus.EX_ctrl   <= '0;
    end else begin
      case (upd)
        // Squash and bubble both leave a side-effect-free slot; data fields hold.
        UPD_FLUSH, UPD_BUBBLE: begin
          bus.EX_valid <= 1'b0;
          bus.EX_ctrl  <= '0;
        end
        UPD_LOAD: begin
          bus.EX_valid  <= bus.ID_valid;
          bus.EX_rs     <= bus.ID_rs;
          bus.EX_rt     <= bus.ID_rt;
          bus.EX_rd     <= bus.ID_rd;
          bus.EX_rdata1 <= bus.ID_rdata1;
          bus.EX_rdata2 <= bus.ID_rdata2;
          bus.EX_imm    <= bus.ID_imm;
          bus.EX_ctrl   <= bus.ID_valid ? bus.ID_ctrl : '0;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [DATA_W-1:0] bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (upd == UPD_BUBBLE && bubble_cnt != '1)
      bubble_cnt <= bubble_cnt + 1'b1;
  end

  assign BubbleCnt = bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: vector table plus
// hand-written reset/stall and (with HAZ_PERF_CNT_EN) counter sequences.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam logic [9:0] LW  = 10'h360;
  localparam logic [9:0] ADD = 10'h212;
  localparam logic [9:0] SW  = 10'h0A0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_if bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave), .BubbleCnt(bubble_cnt));
`else
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] r1, r2, imm;
    logic [9:0]  ctrl;
    logic        flush, hold;
    logic        e_stall;
    logic        e_v;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [31:0] e_r1, e_r2, e_imm;
    logic [9:0]  e_ctrl;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, rt, rd,
                       input logic [31:0] r1, r2, imm, input logic [9:0] ctrl,
                       input logic fl, hd);
    bus.ID_valid  = v;
    bus.ID_rs     = rs;
    bus.ID_rt     = rt;
    bus.ID_rd     = rd;
    bus.ID_rdata1 = r1;
    bus.ID_rdata2 = r2;
    bus.ID_imm    = imm;
    bus.ID_ctrl   = ctrl;
    bus.Flush     = fl;
    bus.Hold      = hd;
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [4:0] rs, rt, rd,
                          input logic [31:0] r1, r2, imm, input logic [9:0] ctrl);
    check({tag, ".valid"},  {31'd0, bus.EX_valid}, {31'd0, v});
    check({tag, ".rs"},     {27'd0, bus.EX_rs},    {27'd0, rs});
    check({tag, ".rt"},     {27'd0, bus.EX_rt},    {27'd0, rt});
    check({tag, ".rd"},     {27'd0, bus.EX_rd},    {27'd0, rd});
    check({tag, ".rdata1"}, bus.EX_rdata1, r1);
    check({tag, ".rdata2"}, bus.EX_rdata2, r2);
    check({tag, ".imm"},    bus.EX_imm,    imm);
    check({tag, ".ctrl"},   {22'd0, bus.EX_ctrl},  {22'd0, ctrl});
  endtask

  // One full cycle: drive at negedge, check Stall before the edge, EX after it.
  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    drive(t.v, t.rs, t.rt, t.rd, t.r1, t.r2, t.imm, t.ctrl, t.flush, t.hold);
    #1;
    check({tag, ".stall"}, {31'd0, bus.Stall}, {31'd0, t.e_stall});
    @(posedge clk);
    #1;
    check_ex(tag, t.e_v, t.e_rs, t.e_rt, t.e_rd, t.e_r1, t.e_r2, t.e_imm, t.e_ctrl);
  endtask

  // Issue and clock one instruction without checking (used in counter runs).
  task automatic issue(input logic [4:0] rs, rt, input logic [9:0] ctrl);
    @(negedge clk);
    drive(1'b1, rs, rt, 5'd0, 32'd0, 32'd0, 32'd0, ctrl, 1'b0, 1'b0);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //            v  rs  rt  rd  r1        r2        imm       ctrl flush hold | stall v  rs  rt  rd  r1        r2        imm       ctrl
    vecs[0]  = '{1, 1,  5,  0,  'h100,    'h0,      'h4,      LW,  0, 0,  0, 1, 1,  5,  0,  'h100,    'h0,      'h4,      LW};
    vecs[1]  = '{1, 5,  7,  6,  'hAAAA,   'h7777,   'h3020,   ADD, 0, 0,  1, 0, 1,  5,  0,  'h100,    'h0,      'h4,      0};
    vecs[2]  = '{1, 5,  7,  6,  'hAAAA,   'h7777,   'h3020,   ADD, 0, 0,  0, 1, 5,  7,  6,  'hAAAA,   'h7777,   'h3020,   ADD};
    vecs[3]  = '{1, 2,  0,  0,  'h200,    'h0,      'h8,      LW,  0, 0,  0, 1, 2,  0,  0,  'h200,    'h0,      'h8,      LW};
    vecs[4]  = '{1, 0,  4,  3,  'h0,      'h44,     'h1820,   ADD, 0, 0,  0, 1, 0,  4,  3,  'h0,      'h44,     'h1820,   ADD};
    vecs[5]  = '{1, 3,  9,  0,  'h300,    'h0,      'h0,      LW,  0, 0,  0, 1, 3,  9,  0,  'h300,    'h0,      'h0,      LW};
    vecs[6]  = '{1, 2,  9,  0,  'h200,    'h99,     'h4,      SW,  1, 0,  0, 0, 3,  9,  0,  'h300,    'h0,      'h0,      0};
    vecs[7]  = '{0, 4,  9,  1,  'h11,     'h22,     'h33,     ADD, 0, 0,  0, 0, 4,  9,  1,  'h11,     'h22,     'h33,     0};
    vecs[8]  = '{1, 4,  7,  0,  'h400,    'h0,      'h0,      LW,  0, 0,  0, 1, 4,  7,  0,  'h400,    'h0,      'h0,      LW};
    vecs[9]  = '{1, 2,  7,  8,  'h2,      'h7,      'h4020,   ADD, 0, 1,  0, 1, 4,  7,  0,  'h400,    'h0,      'h0,      LW};
    vecs[10] = '{1, 1,  2,  3,  'hDEAD,   'hBEEF,   'h1234,   ADD, 0, 1,  0, 1, 4,  7,  0,  'h400,    'h0,      'h0,      LW};
    vecs[11] = '{1, 7,  1,  2,  'h5,      'h6,      'h7,      SW,  0, 1,  0, 1, 4,  7,  0,  'h400,    'h0,      'h0,      LW};
    vecs[12] = '{1, 7,  1,  2,  'h5,      'h6,      'h7,      SW,  0, 0,  1, 0, 4,  7,  0,  'h400,    'h0,      'h0,      0};
    vecs[13] = '{1, 7,  1,  2,  'h5,      'h6,      'h7,      SW,  0, 0,  0, 1, 7,  1,  2,  'h5,      'h6,      'h7,      SW};
    vecs[14] = '{1, 1,  2,  3,  'h1,      'h2,      'h3,      ADD, 1, 0,  0, 0, 7,  1,  2,  'h5,      'h6,      'h7,      0};
    vecs[15] = '{1, 1,  2,  3,  'h1,      'h2,      'h3,      ADD, 0, 0,  0, 1, 1,  2,  3,  'h1,      'h2,      'h3,      ADD};
    vecs[16] = '{1, 9,  9,  9,  'h9,      'h9,      'h9,      LW,  1, 1,  0, 0, 1,  2,  3,  'h1,      'h2,      'h3,      0};
    vecs[17] = '{1, 6,  5,  0,  'h600,    'h0,      'h0,      LW,  0, 0,  0, 1, 6,  5,  0,  'h600,    'h0,      'h0,      LW};
    vecs[18] = '{0, 5,  5,  0,  'h1,      'h1,      'h1,      ADD, 0, 0,  0, 0, 5,  5,  0,  'h1,      'h1,      'h1,      0};

    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 10'd0, 1'b0, 1'b0);

    // Asynchronous reset before the first clock edge
    #1 rst = 1'b1;
    #1;
    check_ex("reset", 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 10'd0);
    check("reset.stall", {31'd0, bus.Stall}, 32'd0);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) step(vecs[i], $sformatf("v%0d", i));

    // Reset mid-stall: bubble discarded, dependent instruction loads next edge
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd5, 5'd0, 32'h100, 32'd0, 32'd4, LW, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd7, 5'd6, 32'hAAAA, 32'h7777, 32'h3020, ADD, 1'b0, 1'b0);
    #1;
    check("midrst.pre_stall", {31'd0, bus.Stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_ex("midrst", 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 10'd0);
    check("midrst.stall", {31'd0, bus.Stall}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_ex("postrst", 1'b1, 5'd5, 5'd7, 5'd6, 32'hAAAA, 32'h7777, 32'h3020, ADD);

`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    #1 check("cnt.reset", bubble_cnt, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(5'd1, 5'd5, LW);
      issue(5'd5, 5'd7, ADD);
      issue(5'd5, 5'd7, ADD);
    end
    #1 check("cnt.four", bubble_cnt, 32'd4);
    @(negedge clk);
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt;
    issue(5'd1, 5'd5, LW);
    issue(5'd5, 5'd7, ADD);
    issue(5'd5, 5'd7, ADD);
    #1 check("cnt.saturate", bubble_cnt, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: ID_valid  in  1  decode slot holds a real instruction.
REQ-004 SHALL have ports: ID_rs, ID_rt, ID_rd  in  5 each  decoded register numbers.
REQ-005 SHALL have ports: ID_rdata1, ID_rdata2, ID_imm  in  32 each  register-file read data, sign-extended immediate.
REQ-006 SHALL have ports: ID_ctrl  in  10  control bundle {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[3:0]}.
REQ-007 SHALL have ports: Flush  in  1  squash (taken branch/jump resolved in EX).
REQ-008 SHALL have ports: Hold  in  1  downstream memory not ready; freeze stage.
REQ-009 SHALL have ports: Stall  out  1  load-use stall request to PC and IF/ID.
REQ-010 SHALL have ports: EX_valid, EX_rs, EX_rt, EX_rd, EX_rdata1, EX_rdata2, EX_imm, EX_ctrl  out  widths as ID_*  registered EX-stage state (EX_rs/EX_rt feed the forwarding unit).

Function
REQ-011 SHALL compute Stall combinationally: EX_valid & EX_ctrl.MemRead & ID_valid & EX_rt!=0 & (EX_rt==ID_rs | EX_rt==ID_rt).
REQ-012 SHALL force Stall=0 while Flush=1 or Hold=1.
REQ-013 SHALL update at each rising clk with priority Flush > Hold > Stall > Load.
REQ-014 Flush: EX_valid<=0, EX_ctrl<=0; other EX_* fields don't-care (held).
REQ-015 Hold (no Flush): all EX_* registers keep their values.
REQ-016 Stall (no Flush/Hold): bubble inserted -- EX_valid<=0, EX_ctrl<=0; no load; next cycle the same ID instruction re-evaluates with Stall=0 (exactly one bubble per load-use).
REQ-017 Load: every EX_* <= corresponding ID_*; EX_valid<=ID_valid; EX_ctrl<=ID_valid ? ID_ctrl : 0.
REQ-018 SHALL guarantee EX_ctrl==0 whenever EX_valid==0 (no architectural side effect from bubbles).
REQ-019 Latency: ID inputs appear on EX outputs one clock after a Load cycle.
REQ-020 Register $0 SHALL never trigger Stall.
REQ-021 Stall and Hold simultaneously: Hold wins; Stall re-evaluated after Hold deasserts.

Reset
REQ-022 rst=1 SHALL asynchronously clear all EX_* registers to 0 (EX_valid=0, EX_ctrl=0); Stall thus reads 0.
REQ-023 Reset mid-stall SHALL discard the pending bubble; first cycle after release behaves as Load.

Configuration
REQ-024 Macro HAZ_PERF_CNT_EN: when defined, SHALL add output BubbleCnt (32, out) counting cycles in which a Stall bubble is inserted (REQ-016), saturating at 0xFFFFFFFF, cleared by rst.
REQ-025 Without HAZ_PERF_CNT_EN, BubbleCnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-026 Control-bundle bit positions, widths (CTRL_W=10, REG_W=5, DATA_W=32) SHALL live in the shared pipeline package used by all stages.
REQ-027 Load-use detector SHALL be a separate combinational sub-module hazard_detect; the pipeline register and counter stay in id_ex_stage.

Verification
REQ-028 Reset: assert rst mid-cycle -> all EX_* = 0, Stall=0 immediately, without clock edge.
REQ-029 Load-use: EX holds lw $5 (MemRead=1, EX_rt=5); ID add $6,$5,$7 -> Stall=1; next edge EX_valid=0, EX_ctrl=0; following edge EX_rs=5, EX_valid=1, Stall=0.
REQ-030 $0 case: EX lw to $0, ID uses rs=0 -> Stall=0, normal Load.
REQ-031 Flush vs Stall: load-use condition plus Flush=1 -> Stall=0, EX_valid=0 next cycle.
REQ-032 Hold: Hold=1 for 3 cycles with changing ID_* -> EX_* constant; Hold=0 -> Load of current ID_*.
REQ-033 With HAZ_PERF_CNT_EN: 4 back-to-back load-use pairs -> BubbleCnt=4; preload 0xFFFFFFFF by forcing, one more bubble -> stays 0xFFFFFFFF.
